// File: rtl/router_pkg.sv
// Shared definitions for the router output-steering logic: port count, address
// encoding and the one-hot address decode used by the sync stage.
package router_pkg;

  localparam int NUM_PORTS       = 3;
  localparam int ADDR_W          = 2;
  localparam int DEFAULT_TIMEOUT = 30;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef logic [NUM_PORTS-1:0] port_vec_t;

  // Unmapped addresses (only ADDR_INVALID today) decode to all zeros.
  function automatic port_vec_t addr_onehot(input logic [ADDR_W-1:0] addr);
    port_vec_t vec;
    vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      vec[i] = (addr == ADDR_W'(i));
    end
    return vec;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port stall timer: counts consecutive cycles of valid-but-unread data and
// emits a single-cycle soft_reset pulse when the count reaches TIMEOUT.
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stall;

  assign stall = vld && !rd;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= 1'b0;
      if (!stall) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Restart from zero so a still-visible FIFO cannot pulse back-to-back.
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_sync.sv
// Steering stage between the router FSM and the output FIFOs: latches the
// destination address, decodes writes, muxes full, and runs per-port timeouts.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  port_vec_t         read_enb,
  input  port_vec_t         empty,
  input  port_vec_t         full,
  output port_vec_t         write_enb,
  output logic              fifo_full,
  output port_vec_t         vld_out,
  output port_vec_t         soft_reset
);

  logic [ADDR_W-1:0] addr_q;
  port_vec_t         addr_sel;

  // NOTE: reset to the invalid address so nothing is written or reported full
  // until the FSM has actually decoded a header.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= ADDR_INVALID;
    end else if (detect_add) begin
      addr_q <= data_in;
    end
  end

  // NOTE: every output of this block is assigned on every pass, so no latch
  // can be inferred whatever addr_q holds.
  always_comb begin
    addr_sel  = addr_onehot(addr_q);
    write_enb = write_enb_reg ? addr_sel : '0;
    fifo_full = |(full & addr_sel);
  end

  assign vld_out = ~empty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[i]),
      .rd         (read_enb[i]),
      .soft_reset (soft_reset[i])
    );
  end

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: reset values, address decode and full mux,
// invalid address, and timeout pulse / abort / concurrency / reset behaviour.
module tb_router_sync;

  logic       clock;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] read_enb;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  int n_vec = 0;
  int n_err = 0;

  router_sync dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb      (read_enb),
    .empty         (empty),
    .full          (full),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out       (vld_out),
    .soft_reset    (soft_reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One rising edge; returns at the following falling edge, where outputs are
  // sampled and inputs changed.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Advance n edges checking that no pulse appears on any port.
  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(soft_reset), 32'h0);
    end
  endtask

  initial begin
    resetn        = 1'b1;
    detect_add    = 1'b0;
    data_in       = 2'd0;
    write_enb_reg = 1'b1;
    read_enb      = 3'b000;
    empty         = 3'b111;
    full          = 3'b010;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 resetn = 1'b0;
    #1;
    check("rst_write_enb", 32'(write_enb), 32'h0);
    check("rst_fifo_full", 32'(fifo_full), 32'h0);
    check("rst_vld_out",   32'(vld_out),   32'h0);
    check("rst_soft_reset", 32'(soft_reset), 32'h0);
    @(negedge clock);
    tick();
    resetn = 1'b1;
    tick();

    // Decode to port 2; capture only takes effect after the edge.
    detect_add = 1'b1;
    data_in    = 2'd2;
    #1 check("dec_pre_edge", 32'(write_enb), 32'h0);
    tick();
    detect_add = 1'b0;
    data_in    = 2'd0;
    #1 check("dec_p2_write", 32'(write_enb), 32'h4);
    full = 3'b100;
    #1 check("dec_p2_full1", 32'(fifo_full), 32'h1);
    full = 3'b011;
    #1 check("dec_p2_full0", 32'(fifo_full), 32'h0);
    tick();
    check("dec_hold", 32'(write_enb), 32'h4);
    write_enb_reg = 1'b0;
    #1 check("dec_no_req", 32'(write_enb), 32'h0);
    write_enb_reg = 1'b1;

    // Ports 0 and 1: one-hot write, full muxed from only that port.
    for (int a = 0; a < 2; a++) begin
      detect_add = 1'b1;
      data_in    = 2'(a);
      tick();
      detect_add = 1'b0;
      full       = 3'b001 << a;
      #1;
      check($sformatf("dec_p%0d_write", a), 32'(write_enb), 32'(3'b001 << a));
      check($sformatf("dec_p%0d_full", a), 32'(fifo_full), 32'h1);
      full = ~(3'b001 << a);
      #1 check($sformatf("dec_p%0d_nfull", a), 32'(fifo_full), 32'h0);
    end

    // Invalid address drops writes and never reports full.
    detect_add = 1'b1;
    data_in    = 2'd3;
    tick();
    detect_add = 1'b0;
    full       = 3'b111;
    #1;
    check("inv_write", 32'(write_enb), 32'h0);
    check("inv_full",  32'(fifo_full), 32'h0);
    write_enb_reg = 1'b0;

    // Port 1 timeout: pulse after the 30th edge, exactly one cycle wide.
    empty = 3'b101;
    #1 check("vld_p1", 32'(vld_out), 32'h2);
    quiet("to1_early", 29);
    tick();
    check("to1_pulse", 32'(soft_reset), 32'h2);
    tick();
    check("to1_single", 32'(soft_reset), 32'h0);
    empty = 3'b111;
    tick();

    // Port 0: read on the 30th edge suppresses the pulse.
    empty = 3'b110;
    quiet("rd_abort_pre", 29);
    read_enb = 3'b001;
    quiet("rd_abort_edge", 1);
    read_enb = 3'b000;

    // Port 0: going empty on edge 15 clears the count; 30 fresh edges pulse once.
    quiet("emp_abort_pre", 14);
    empty = 3'b111;
    quiet("emp_abort_edge", 1);
    empty = 3'b110;
    quiet("emp_restart", 29);
    tick();
    check("emp_pulse", 32'(soft_reset), 32'h1);
    tick();
    check("emp_single", 32'(soft_reset), 32'h0);
    empty = 3'b111;
    tick();

    // Ports 0 and 2 together pulse on the same cycle.
    empty = 3'b010;
    quiet("conc_pre", 29);
    tick();
    check("conc_pulse", 32'(soft_reset), 32'h5);
    tick();
    check("conc_single", 32'(soft_reset), 32'h0);
    empty = 3'b111;
    tick();

    // Reset at edge 20 restarts the count; a reset mid-pulse clears it at once.
    empty = 3'b110;
    quiet("rstmid_pre", 19);
    resetn = 1'b0;
    #1 check("rstmid_async", 32'(soft_reset), 32'h0);
    tick();
    resetn = 1'b1;
    quiet("rstmid_recount", 29);
    tick();
    check("rstmid_pulse", 32'(soft_reset), 32'h1);
    resetn = 1'b0;
    #1 check("rst_mid_pulse", 32'(soft_reset), 32'h0);
    #1 resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
